// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//   Shares one character-LCD write path (LCD_Controller: iStart/oDone, iRS,
//   iDATA) between two byte-write requesters. After reset it sends the fixed
//   HD44780 init sequence. It then grants the requesters round-robin. Each
//   write is held through the controller done and a settle delay, and is then
//   acknowledged to its requester.
//
// Ports
//   iCLK, iRST_N           clock (posedge), asynchronous active-low reset
//   iREQ0, iRS0, iDATA0    requester 0 request/register-select/byte
//   oACK0                  requester 0 one-cycle write-complete pulse
//   iREQ1, iRS1, iDATA1    requester 1 request/register-select/byte
//   oACK1                  requester 1 one-cycle write-complete pulse
//   oLCD_START             to controller iStart (held until done)
//   oLCD_RS, oLCD_DATA     to controller iRS / iDATA (held between writes)
//   iLCD_DONE              from controller oDone
//   oINIT_DONE             sticky flag, init sequence finished
module lcd_write_arbiter #(
    parameter int DLY_W      = 18,
    parameter int DLY_CYCLES = 262143
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iREQ0,
    input  logic       iRS0,
    input  logic [7:0] iDATA0,
    output logic       oACK0,
    input  logic       iREQ1,
    input  logic       iRS1,
    input  logic [7:0] iDATA1,
    output logic       oACK1,
    output logic       oLCD_START,
    output logic       oLCD_RS,
    output logic [7:0] oLCD_DATA,
    input  logic       iLCD_DONE,
    output logic       oINIT_DONE
);

    typedef enum logic [2:0] {
        INIT_ISSUE, INIT_WAIT, INIT_DLY, IDLE, WAIT, DLY, ACK
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [DLY_W-1:0] cnt, cnt_nxt;
    logic             ptr, ptr_nxt;        // 0: favour requester 0 on a tie
    logic             gnt, gnt_nxt;        // id of the write in flight
    logic             start, start_nxt;
    logic             rs, rs_nxt;
    logic [7:0]       data, data_nxt;
    logic             ack0, ack0_nxt;
    logic             ack1, ack1_nxt;
    logic             init_done, init_done_nxt;

    logic             last_cnt;
    logic             sel_valid;
    logic             sel_id;

    function automatic logic [7:0] init_rom(input logic [2:0] i);
        case (i)
            3'd0:    init_rom = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            3'd1:    init_rom = 8'h0C;   // display on, cursor off
            3'd2:    init_rom = 8'h01;   // clear display
            3'd3:    init_rom = 8'h06;   // entry mode: increment, no shift
            default: init_rom = 8'h80;   // DDRAM address 0
        endcase
    endfunction

    // Settle window ends on the count DLY_CYCLES-1, giving exactly DLY_CYCLES cycles.
    assign last_cnt  = (cnt == DLY_W'(DLY_CYCLES - 1));
    assign sel_valid = iREQ0 | iREQ1;
    assign sel_id    = (iREQ0 && iREQ1) ? ptr : iREQ1;

    // State and datapath registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= INIT_ISSUE;
            idx       <= 3'd0;
            cnt       <= '0;
            ptr       <= 1'b0;
            gnt       <= 1'b0;
            start     <= 1'b0;
            rs        <= 1'b0;
            data      <= 8'h00;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            start     <= start_nxt;
            rs        <= rs_nxt;
            data      <= data_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            init_done <= init_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            INIT_ISSUE: state_nxt = INIT_WAIT;
            INIT_WAIT:  if (iLCD_DONE) state_nxt = INIT_DLY;
            INIT_DLY:   if (last_cnt) state_nxt = (idx == 3'd4) ? IDLE : INIT_ISSUE;
            IDLE:       if (sel_valid) state_nxt = WAIT;
            WAIT:       if (iLCD_DONE) state_nxt = DLY;
            DLY:        if (last_cnt) state_nxt = ACK;
            ACK:        state_nxt = IDLE;
            default:    state_nxt = INIT_ISSUE;
        endcase
    end

    // Output and datapath next values; ack is set on the way into ACK so it
    // is high for exactly the one ACK cycle.
    always_comb begin
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        gnt_nxt       = gnt;
        start_nxt     = start;
        rs_nxt        = rs;
        data_nxt      = data;
        ack0_nxt      = 1'b0;
        ack1_nxt      = 1'b0;
        init_done_nxt = init_done;
        case (state)
            INIT_ISSUE: begin
                start_nxt = 1'b1;
                rs_nxt    = 1'b0;
                data_nxt  = init_rom(idx);
            end
            INIT_WAIT: begin
                if (iLCD_DONE) begin
                    start_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            INIT_DLY: begin
                cnt_nxt = cnt + 1'b1;
                if (last_cnt) begin
                    if (idx == 3'd4) init_done_nxt = 1'b1;
                    else             idx_nxt       = idx + 3'd1;
                end
            end
            IDLE: begin
                if (sel_valid) begin
                    rs_nxt    = sel_id ? iRS1 : iRS0;
                    data_nxt  = sel_id ? iDATA1 : iDATA0;
                    start_nxt = 1'b1;
                    gnt_nxt   = sel_id;
                    ptr_nxt   = ~sel_id;
                end
            end
            WAIT: begin
                if (iLCD_DONE) begin
                    start_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            DLY: begin
                cnt_nxt = cnt + 1'b1;
                if (last_cnt) begin
                    ack0_nxt = ~gnt;
                    ack1_nxt = gnt;
                end
            end
            default: begin
            end
        endcase
    end

    assign oLCD_START = start;
    assign oLCD_RS    = rs;
    assign oLCD_DATA  = data;
    assign oACK0      = ack0;
    assign oACK1      = ack1;
    assign oINIT_DONE = init_done;

endmodule
